// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a two-flop synchroniser,
// mid-bit sampling, framing-error detection and break hold-off.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  // Synchroniser flops reset to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            if (idx == LAST) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A held-low line waits here so it cannot spawn repeated frames.
        S_BRK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and random frames against a byte-level
// reference (expected byte queue, frame-latency formula).
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + (DB + 1) * CPB + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] val_q[$];
  int         val_t[$];
  int         st_t[$];
  int         err_n  = 0;
  int         busy_n = 0;
  int         both_n = 0;

  int vb, eb, bb, sb;
  int ne;
  logic [7:0] b;
  logic [7:0] last;
  logic [7:0] exp_q[$];
  bit good;

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        val_q.push_back(rx_data);
        val_t.push_back(cyc);
      end
      if (frame_err) err_n++;
      if (busy) busy_n++;
      if (rx_valid && frame_err) both_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    vectors++;
    assert (obs >= lo && obs <= hi) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic mark();
    vb = val_q.size();
    eb = err_n;
    bb = busy_n;
    sb = st_t.size();
  endtask

  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    if (stop) st_t.push_back(cyc);
    hold(1'b0, CPB);
    for (int i = 0; i < DB; i++) hold(d[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic chk_frames(input string tag, input int n);
    chk({tag, "_count"}, val_q.size() - vb, n);
    for (int i = 0; i < n; i++) begin
      if (vb + i < val_q.size() && sb + i < st_t.size())
        chk_rng({tag, "_lat"}, val_t[vb+i] - st_t[sb+i], LAT - 1, LAT + 1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    mark();
    hold(1'b1, 100);
    chk("idle_valid", val_q.size() - vb, 0);
    chk("idle_err", err_n - eb, 0);
    chk("idle_busy", busy_n - bb, 0);
    chk("idle_data", rx_data, 8'h00);

    mark();
    send(8'hA5, 1'b1);
    hold(1'b1, 40);
    chk_frames("a5", 1);
    if (val_q.size() > vb) chk("a5_data", val_q[vb], 8'hA5);
    chk("a5_err", err_n - eb, 0);
    chk("a5_busy", busy, 1'b0);

    mark();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b1);
    hold(1'b1, 40);
    chk_frames("b2b", 3);
    if (val_q.size() >= vb + 3) begin
      chk("b2b_d0", val_q[vb], 8'h00);
      chk("b2b_d1", val_q[vb+1], 8'hFF);
      chk("b2b_d2", val_q[vb+2], 8'h3C);
      chk("b2b_gap1", val_t[vb+1] - val_t[vb], 10 * CPB);
      chk("b2b_gap2", val_t[vb+2] - val_t[vb+1], 10 * CPB);
    end
    chk("b2b_err", err_n - eb, 0);

    mark();
    hold(1'b0, 4);
    hold(1'b1, 40);
    chk_rng("glitch_busy", busy_n - bb, 6, 12);
    chk("glitch_valid", val_q.size() - vb, 0);
    chk("glitch_err", err_n - eb, 0);
    mark();
    send(8'h5A, 1'b1);
    hold(1'b1, 40);
    chk_frames("g5a", 1);
    if (val_q.size() > vb) chk("g5a_data", val_q[vb], 8'h5A);

    mark();
    send(8'h81, 1'b0);
    hold(1'b0, 2 * CPB);
    chk("ferr_busy_hi", busy, 1'b1);
    chk("ferr_pulses", err_n - eb, 1);
    chk("ferr_valid", val_q.size() - vb, 0);
    chk("ferr_data", rx_data, 8'h5A);
    hold(1'b1, 10);
    chk("ferr_busy_lo", busy, 1'b0);
    mark();
    send(8'h42, 1'b1);
    hold(1'b1, 40);
    chk_frames("f42", 1);
    if (val_q.size() > vb) chk("f42_data", val_q[vb], 8'h42);

    mark();
    b = 8'h96;
    hold(1'b0, CPB);
    for (int i = 0; i < 3; i++) hold(b[i], CPB);
    hold(b[3], HALF);
    rst   = 1'b1;
    rx_in = 1'b1;
    #1;
    chk("arst_data", rx_data, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", rx_valid, 1'b0);
    chk("arst_err", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 20);
    mark();
    send(8'hC3, 1'b1);
    hold(1'b1, 40);
    chk_frames("c3", 1);
    if (val_q.size() > vb) chk("c3_data", val_q[vb], 8'hC3);
    chk("c3_err", err_n - eb, 0);

    mark();
    ne   = 0;
    last = 8'hC3;
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send(b, good);
      if (good) begin
        exp_q.push_back(b);
        last = b;
        hold(1'b1, $urandom_range(0, 20));
      end else begin
        ne++;
        hold(1'b1, $urandom_range(4, 20));
      end
    end
    hold(1'b1, 40);
    chk("rnd_count", val_q.size() - vb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (vb + i < val_q.size()) chk("rnd_data", val_q[vb+i], exp_q[i]);
    end
    chk("rnd_err", err_n - eb, ne);
    chk("rnd_hold", rx_data, last);
    chk("both_pulses", both_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
